// File: rtl/nn_pkg.sv
// Shared types and helpers for the stochastic-neuron burst-gate blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    BG_INTEGRATE,
    BG_BURST,
    BG_REFRACT
  } bg_state_t;

  // Timer width: wide enough for BURST_LEN-1 and REFRACT_LEN-1, never below 1 bit.
  function automatic int bg_timer_w(input int burst_len, input int refract_len);
    int m;
    m = 2;
    if (burst_len > m) m = burst_len;
    if (refract_len > m) m = refract_len;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/nn_sat_updown.sv
// Saturating up/down counter with synchronous load; cnt_next exposes the value the next enabled edge commits.
module nn_sat_updown
  import nn_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int RST_VAL = 32
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             up,
  input  logic             down,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] MAX_C = '1;

  logic [CNT_W-1:0] cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (load)
      cnt_next = load_val;
    else if (up && !down && (cnt_reg != MAX_C))
      cnt_next = cnt_reg + CNT_W'(1);
    else if (down && !up && (cnt_reg != '0))
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT)
      cnt_reg <= CNT_W'(RST_VAL);
    else if (en)
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/nn_burst_gate.sv
// Burst-gate activation: integrate x, fire a BURST_LEN burst on z, then a refractory gap.
// Optional leak toward MID every LEAK_PERIOD integrate cycles when NN_BG_LEAK_EN is defined.
module nn_burst_gate
  import nn_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int MID         = 32,
  parameter int THRESH      = 48,
  parameter int BURST_LEN   = 4,
  parameter int REFRACT_LEN = 2,
  parameter int LEAK_PERIOD = 16
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             x,
  output logic             z,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  localparam int TW = bg_timer_w(BURST_LEN, REFRACT_LEN);
  localparam logic [CNT_W-1:0] MID_C    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [TW-1:0]    BURST_T  = TW'(BURST_LEN - 1);
  localparam logic [TW-1:0]    REFR_T   = TW'((REFRACT_LEN > 0) ? REFRACT_LEN - 1 : 0);

  bg_state_t        state_reg;
  logic [TW-1:0]    timer_reg;
  logic             z_reg;
  logic             busy_reg;

  logic             cnt_load;
  logic             cnt_up;
  logic             cnt_down;
  logic [CNT_W-1:0] cnt_next;
  logic             fire;
  logic             leak_tick;

`ifdef NN_BG_LEAK_EN
  localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  logic [LW-1:0] leak_cnt_reg;

  assign leak_tick = (leak_cnt_reg == LW'(LEAK_PERIOD - 1));

  // Counts enabled INTEGRATE cycles; restarts on every burst so each integration begins fresh.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT)
      leak_cnt_reg <= '0;
    else if (EN && (state_reg == BG_INTEGRATE)) begin
      if (fire || leak_tick)
        leak_cnt_reg <= '0;
      else
        leak_cnt_reg <= leak_cnt_reg + LW'(1);
    end
  end
`else
  logic unused_leak;
  assign unused_leak = |LEAK_PERIOD;
  assign leak_tick   = 1'b0;
`endif

  always_comb begin
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    case (state_reg)
      BG_INTEGRATE: begin
        if (leak_tick) begin
          cnt_up   = (cnt < MID_C);
          cnt_down = (cnt > MID_C);
        end else begin
          cnt_up   = x;
          cnt_down = !x;
        end
      end
      BG_BURST: cnt_load = (timer_reg == '0);
      default: ;
    endcase
  end

  // Threshold is judged on the post-step value so z rises on the edge that reaches THRESH.
  assign fire = (state_reg == BG_INTEGRATE) && (cnt_next >= THRESH_C);

  nn_sat_updown #(
    .CNT_W   (CNT_W),
    .RST_VAL (MID)
  ) u_integ (
    .CLK      (CLK),
    .INIT     (INIT),
    .en       (EN),
    .load     (cnt_load),
    .load_val (MID_C),
    .up       (cnt_up),
    .down     (cnt_down),
    .cnt      (cnt),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_reg <= BG_INTEGRATE;
      timer_reg <= '0;
      z_reg     <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (EN) begin
      case (state_reg)
        BG_INTEGRATE: begin
          if (fire) begin
            state_reg <= BG_BURST;
            timer_reg <= BURST_T;
            z_reg     <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        BG_BURST: begin
          if (timer_reg == '0) begin
            z_reg <= 1'b0;
            if (REFRACT_LEN == 0) begin
              state_reg <= BG_INTEGRATE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= BG_REFRACT;
              timer_reg <= REFR_T;
            end
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        BG_REFRACT: begin
          if (timer_reg == '0) begin
            state_reg <= BG_INTEGRATE;
            busy_reg  <= 1'b0;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        default: begin
          state_reg <= BG_INTEGRATE;
          z_reg     <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign z    = z_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_nn_burst_gate.sv
// Directed bench for nn_burst_gate; define NN_BG_LEAK_EN to exercise the leak variant.
module tb_nn_burst_gate;

  logic       CLK;
  logic       INIT;
  logic       EN;
  logic       x;
  logic       z;
  logic       busy;
  logic [5:0] cnt;

  int vectors;
  int miscompares;

  nn_burst_gate dut (
    .CLK  (CLK),
    .INIT (INIT),
    .EN   (EN),
    .x    (x),
    .z    (z),
    .busy (busy),
    .cnt  (cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_init();
    INIT = 1'b0;
    #2;
    INIT = 1'b1;
  endtask

  task automatic test_reset();
    INIT = 1'b0; EN = 1'b1; x = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (z !== 1'b0 || busy !== 1'b0 || cnt !== 6'd32) begin
        miscompares++;
        $display("FAIL reset e%0d: z=%b busy=%b cnt=%0d, want z=0 busy=0 cnt=32", e, z, busy, cnt);
      end else
        $display("reset e%0d: z=%b busy=%b cnt=%0d", e, z, busy, cnt);
    end
    INIT = 1'b1;
  endtask

`ifdef NN_BG_LEAK_EN
  task automatic test_leak();
    logic [5:0] ecnt;
    logic       ez;
    pulse_init();
    EN = 1'b1; x = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e <= 15)      ecnt = 6'(32 + e);
      else if (e == 16) ecnt = 6'd46;
      else if (e == 17) ecnt = 6'd47;
      else              ecnt = 6'd48;
      ez = (e == 18);
      vectors++;
      if (cnt !== ecnt || z !== ez) begin
        miscompares++;
        $display("FAIL leak e%0d: cnt=%0d z=%b, want cnt=%0d z=%b", e, cnt, z, ecnt, ez);
      end else
        $display("leak e%0d: cnt=%0d z=%b", e, cnt, z);
    end
  endtask
`else
  task automatic test_fire();
    logic [5:0] ecnt;
    logic       ez, eb;
    int         ph;
    pulse_init();
    EN = 1'b1; x = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      tick();
      if (e < 16) begin
        ecnt = 6'(32 + e); ez = 1'b0; eb = 1'b0;
      end else begin
        ph = (e - 16) % 22;
        ez = (ph < 4);
        eb = (ph < 6);
        if (ph < 4)       ecnt = 6'd48;
        else if (ph <= 6) ecnt = 6'd32;
        else              ecnt = 6'(32 + ph - 6);
      end
      vectors++;
      if (cnt !== ecnt || z !== ez || busy !== eb) begin
        miscompares++;
        $display("FAIL fire e%0d: cnt=%0d z=%b busy=%b, want cnt=%0d z=%b busy=%b",
                 e, cnt, z, busy, ecnt, ez, eb);
      end else
        $display("fire e%0d: cnt=%0d z=%b busy=%b", e, cnt, z, busy);
    end
  endtask

  task automatic test_sat_low();
    logic [5:0] ecnt;
    pulse_init();
    EN = 1'b1; x = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      ecnt = (e >= 32) ? 6'd0 : 6'(32 - e);
      vectors++;
      if (cnt !== ecnt || z !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_low e%0d: cnt=%0d z=%b busy=%b, want cnt=%0d z=0 busy=0",
                 e, cnt, z, busy, ecnt);
      end else
        $display("sat_low e%0d: cnt=%0d z=%b", e, cnt, z);
    end
  endtask

  task automatic test_en_hold();
    logic [5:0] ecnt;
    logic       ez, eb;
    pulse_init();
    EN = 1'b1; x = 1'b1;
    for (int e = 1; e <= 17; e++) tick();
    vectors++;
    if (z !== 1'b1 || cnt !== 6'd48) begin
      miscompares++;
      $display("FAIL en_hold pre: z=%b cnt=%0d, want z=1 cnt=48", z, cnt);
    end else
      $display("en_hold pre: z=%b cnt=%0d", z, cnt);
    EN = 1'b0; x = 1'b0;
    for (int h = 1; h <= 3; h++) begin
      tick();
      vectors++;
      if (z !== 1'b1 || busy !== 1'b1 || cnt !== 6'd48) begin
        miscompares++;
        $display("FAIL en_hold hold%0d: z=%b busy=%b cnt=%0d, want z=1 busy=1 cnt=48", h, z, busy, cnt);
      end else
        $display("en_hold hold%0d: z=%b busy=%b cnt=%0d", h, z, busy, cnt);
    end
    EN = 1'b1; x = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ez   = (k <= 2);
      eb   = (k <= 4);
      ecnt = (k <= 2) ? 6'd48 : 6'd32;
      vectors++;
      if (z !== ez || busy !== eb || cnt !== ecnt) begin
        miscompares++;
        $display("FAIL en_hold k%0d: z=%b busy=%b cnt=%0d, want z=%b busy=%b cnt=%0d",
                 k, z, busy, cnt, ez, eb, ecnt);
      end else
        $display("en_hold k%0d: z=%b busy=%b cnt=%0d", k, z, busy, cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic ez;
    pulse_init();
    EN = 1'b1; x = 1'b1;
    for (int e = 1; e <= 17; e++) tick();
    INIT = 1'b0;
    #1;
    vectors++;
    if (z !== 1'b0 || busy !== 1'b0 || cnt !== 6'd32) begin
      miscompares++;
      $display("FAIL mid_reset async: z=%b busy=%b cnt=%0d, want z=0 busy=0 cnt=32", z, busy, cnt);
    end else
      $display("mid_reset async: z=%b busy=%b cnt=%0d", z, busy, cnt);
    #2;
    INIT = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      ez = (e == 16);
      vectors++;
      if (z !== ez || cnt !== 6'(32 + e)) begin
        miscompares++;
        $display("FAIL mid_reset e%0d: z=%b cnt=%0d, want z=%b cnt=%0d", e, z, cnt, ez, 32 + e);
      end else
        $display("mid_reset e%0d: z=%b cnt=%0d", e, z, cnt);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    INIT = 1'b0; EN = 1'b0; x = 1'b0;
    test_reset();
`ifdef NN_BG_LEAK_EN
    test_leak();
`else
    test_fire();
    test_sat_low();
    test_en_hold();
    test_reset_mid_burst();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
